// File: rtl/crc_stream_engine.sv
// crc_stream_engine: frame-aware, parametrised CRC engine.
// Consumes DATA_W bits per accepted beat, MSB first, for any width, polynomial,
// initial value and output XOR. Each frame is closed by last_in or discarded by
// abort_in. A closed frame produces a registered one-cycle strobe carrying the
// CRC and the frame length.
// Build option: define CRC_CHECK_EN to compile in the residue comparator that
// drives match_out. Without it, match_out is tied to 0.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no frame open; running register holds INIT, beat count is 0
// ST_ACTIVE | frame open; register and count include every accepted beat
module crc_stream_engine #(
  parameter int unsigned      CRC_W         = 32,
  parameter logic [CRC_W-1:0] POLY          = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT          = '1,
  parameter logic [CRC_W-1:0] XOR_OUT       = '0,
  parameter int unsigned      DATA_W        = 8,
  parameter int unsigned      LEN_W         = 16,
  parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              data_valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  input  logic              abort_in,
  output logic              busy_out,
  output logic              crc_valid_out,
  output logic [CRC_W-1:0]  crc_out,
  output logic [LEN_W-1:0]  frame_len_out,
  output logic              match_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // The whole beat is unrolled bit by bit within a single cycle.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_i,
                                                input logic [DATA_W-1:0] data_i);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_i;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data_i[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d, crc_upd;
  logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               valid_q, valid_d;
  logic [CRC_W-1:0]   res_q, res_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               beat_ok, frame_end;

  // Abort overrides any beat presented in the same cycle, including last.
  assign beat_ok   = data_valid_in & ~abort_in;
  assign frame_end = beat_ok & last_in;

  // Next-state, running register, beat counter and result capture.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    res_d   = res_q;
    len_d   = len_q;
    crc_upd = crc_step(crc_q, data_in);
    cnt_inc = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 1'b1;
    if (abort_in) begin
      state_d = ST_IDLE;
      crc_d   = INIT;
      cnt_d   = '0;
    end else if (data_valid_in) begin
      if (last_in) begin
        // The register is already INIT in IDLE, so single-beat frames need no special case.
        state_d = ST_IDLE;
        crc_d   = INIT;
        cnt_d   = '0;
        valid_d = 1'b1;
        res_d   = crc_upd ^ XOR_OUT;
        len_d   = cnt_inc;
      end else begin
        state_d = ST_ACTIVE;
        crc_d   = crc_upd;
        cnt_d   = cnt_inc;
      end
    end
  end

  // State, running register and result registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      len_q   <= len_d;
    end
  end

  assign busy_out      = (state_q == ST_ACTIVE);
  assign crc_valid_out = valid_q;
  assign crc_out       = res_q;
  assign frame_len_out = len_q;

`ifdef CRC_CHECK_EN
  logic match_q, match_d;

  // Residue compare uses the raw register, before XOR_OUT.
  always_comb begin
    match_d = match_q;
    if (frame_end) match_d = (crc_upd == CHECK_RESIDUE);
  end

  // Match flag, updated with the strobe and held afterwards.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) match_q <= 1'b0;
    else           match_q <= match_d;
  end

  assign match_out = match_q;
`else
  logic unused_residue;
  assign unused_residue = ^{CHECK_RESIDUE, frame_end};
  assign match_out      = 1'b0;
`endif

endmodule
